pipeline_flow_controller: RTL and testbench

//  Parametrised pipeline flow controller; succeeds the fixed 5-stage enable/clear logic in the core control unit.

---
 rtl/pipeline_flow_controller_if.sv | 25 ++
 rtl/pipeline_flow_controller.sv | 86 ++++++++
 tb/tb_pipeline_flow_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_flow_controller_if.sv
// pipeline_flow_controller_if: hazard/stall/irq requests in, stage enables/clears and status out
interface pipeline_flow_controller_if #(
    parameter int NUM_STAGES    = 5,
    parameter int NUM_STALL_SRC = 4
);
    localparam int NR = NUM_STAGES - 1;
    logic                     load_hazard;
    logic                     branch_hazard;
    logic [NUM_STALL_SRC-1:0] stall_req;
    logic                     irq_req;
    logic                     pc_en;
    logic [NR-1:0]            stage_en;
    logic [NR-1:0]            stage_clr;
    logic                     irq_ack;
    logic                     draining;
    logic                     stall_timeout;
    modport master (
        output load_hazard, branch_hazard, stall_req, irq_req,
        input  pc_en, stage_en, stage_clr, irq_ack, draining, stall_timeout
    );
    modport slave (
        input  load_hazard, branch_hazard, stall_req, irq_req,
        output pc_en, stage_en, stage_clr, irq_ack, draining, stall_timeout
    );
endinterface

// File: rtl/pipeline_flow_controller.sv
// pipeline_flow_controller: stage enables/clears from hazards and stalls, interrupt drain FSM, stall watchdog
module pipeline_flow_controller #(
    parameter int NUM_STAGES       = 5,
    parameter int NUM_STALL_SRC    = 4,
    parameter int HAZARD_STAGE     = 1,
    parameter int REDIRECT_STAGE   = 3,
    parameter int MAX_STALL_CYCLES = 64
) (
    input logic clk,
    input logic reset,
    pipeline_flow_controller_if.slave bus
);
    localparam int NR = NUM_STAGES - 1;
    localparam int DW = $clog2(NR + 1);
    localparam int SW = $clog2(MAX_STALL_CYCLES + 1);
    localparam logic [NR-1:0] ONES     = '1;
    localparam logic [NR-1:0] FREEZE   = ONES >> (NR - HAZARD_STAGE);
    localparam logic [NR-1:0] REDIRECT = ONES >> (NR - REDIRECT_STAGE);
    localparam logic [NR-1:0] BUBBLE   = NR'(1) << HAZARD_STAGE;
    localparam logic [NR-1:0] FIRST    = NR'(1);
    typedef enum logic [1:0] {RUN, DRAIN, ACK} state_e;
    state_e        state_q, state_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          stall, drain_now, pc_en;
    logic [NR-1:0] en, clr;
    assign stall     = |bus.stall_req;
    assign drain_now = !stall && (state_q == DRAIN || (state_q == RUN && bus.irq_req));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            dcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            scnt_q  <= scnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        scnt_d  = !stall ? '0 : scnt_q == SW'(MAX_STALL_CYCLES) ? scnt_q : scnt_q + 1'b1;
        if (state_q == RUN && bus.irq_req && !stall) begin
            state_d = DRAIN;
            dcnt_d  = DW'(1);
        end else if (state_q == DRAIN && !stall) begin
            state_d = dcnt_q == DW'(NR) ? ACK : DRAIN;
            dcnt_d  = dcnt_q + 1'b1;
        end else if (state_q == ACK && !stall) begin
            state_d = RUN;
        end
    end
    // A stall freezes everything, including the drain clear and the ACK pulse
    always_comb begin
        pc_en       = 1'b1;
        en          = ONES;
        clr         = '0;
        bus.irq_ack = 1'b0;
        if (stall) begin
            pc_en = 1'b0;
            en    = '0;
        end else if (state_q == ACK) begin
            bus.irq_ack = 1'b1;
            clr         = FIRST;
        end else begin
            if (bus.branch_hazard) begin
                clr = REDIRECT;
            end else if (bus.load_hazard) begin
                pc_en = 1'b0;
                en    = ~FREEZE;
                clr   = BUBBLE;
            end
            if (drain_now) begin
                pc_en = 1'b0;
                clr   = clr | FIRST;
            end
        end
        bus.pc_en     = reset ? 1'b0 : pc_en;
        bus.stage_en  = reset ? '0 : en;
        bus.stage_clr = reset ? ONES : clr;
        if (reset) bus.irq_ack = 1'b0;
    end
    assign bus.draining      = state_q == DRAIN;
    assign bus.stall_timeout = scnt_q == SW'(MAX_STALL_CYCLES);
endmodule

// File: tb/tb_pipeline_flow_controller.sv
// tb_pipeline_flow_controller: directed stimulus, per-cycle check against a behavioural model plus literal checks
module tb_pipeline_flow_controller;
    localparam int NR  = 4;
    localparam int HZ  = 1;
    localparam int RD  = 3;
    localparam int MAX = 64;
    logic clk, reset;
    int   checks = 0, errors = 0;
    int   m_mode, m_left, m_stalls;
    pipeline_flow_controller_if #(.NUM_STAGES(5), .NUM_STALL_SRC(4)) bus ();
    pipeline_flow_controller dut (.clk(clk), .reset(reset), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [12:0] model_out();
        logic pc, ack, dn, st;
        logic [NR-1:0] en, clr;
        st = |bus.stall_req;
        pc = 1'b0; ack = 1'b0; en = '0; clr = '0;
        if (reset) clr = '1;
        else if (st) ;
        else if (m_mode == 2) begin
            pc = 1'b1; ack = 1'b1; en = '1; clr[0] = 1'b1;
        end else begin
            dn = m_mode == 1 || (m_mode == 0 && bus.irq_req);
            for (int k = 0; k < NR; k++) begin
                clr[k] = (bus.branch_hazard && k < RD) ||
                         (!bus.branch_hazard && bus.load_hazard && k == HZ) || (dn && k == 0);
                en[k]  = !(!bus.branch_hazard && bus.load_hazard && k < HZ);
            end
            pc = !dn && (bus.branch_hazard || !bus.load_hazard);
        end
        return {pc, en, clr, ack, !reset && m_mode == 1, !reset && m_stalls == MAX};
    endfunction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_left <= 0; m_stalls <= 0;
        end else begin
            m_stalls <= |bus.stall_req ? (m_stalls < MAX ? m_stalls + 1 : MAX) : 0;
            if (!(|bus.stall_req)) begin
                if (m_mode == 0 && bus.irq_req) begin
                    m_mode <= 1; m_left <= NR;
                end else if (m_mode == 1) begin
                    if (m_left == 1) m_mode <= 2;
                    else m_left <= m_left - 1;
                end else if (m_mode == 2) m_mode <= 0;
            end
        end
    end
    always @(negedge clk) begin
        logic [12:0] exp_v, act;
        exp_v = model_out();
        act = {bus.pc_en, bus.stage_en, bus.stage_clr, bus.irq_ack, bus.draining, bus.stall_timeout};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL model {pc,en,clr,ack,drn,to} at %0t: got %b expected %b", $time, act, exp_v);
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask
    task automatic drive(input logic ld, input logic br, input logic [3:0] st, input logic irq);
        @(posedge clk);
        #1;
        bus.load_hazard = ld; bus.branch_hazard = br; bus.stall_req = st; bus.irq_req = irq;
        @(negedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'b0, 0);
    endtask
    initial begin
        int n, first_hi;
        bit got;
        reset = 1'b1;
        bus.load_hazard = 0; bus.branch_hazard = 0; bus.stall_req = '0; bus.irq_req = 0;
        @(negedge clk); #1;
        chk("reset pc_en", bus.pc_en, 0);
        chk("reset stage_en", bus.stage_en, 4'b0000);
        chk("reset stage_clr", bus.stage_clr, 4'b1111);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk); #1;
        chk("normal pc_en", bus.pc_en, 1);
        chk("normal stage_en", bus.stage_en, 4'b1111);
        chk("normal stage_clr", bus.stage_clr, 4'b0000);
        drive(1, 0, 4'b0, 0);
        chk("load pc_en", bus.pc_en, 0);
        chk("load stage_en", bus.stage_en, 4'b1110);
        chk("load stage_clr", bus.stage_clr, 4'b0010);
        drive(1, 1, 4'b0, 0);
        chk("branch stage_clr", bus.stage_clr, 4'b0111);
        chk("branch pc_en", bus.pc_en, 1);
        drive(1, 1, 4'b0100, 0);
        chk("stall outputs", {bus.pc_en, bus.stage_en, bus.stage_clr}, 9'b0);
        idle(2);
        // plain drain: entry cycle, four DRAIN cycles, one ACK
        drive(0, 0, 4'b0, 1);
        chk("entry pc_en/clr/drn", {bus.pc_en, bus.stage_clr, bus.draining}, {1'b0, 4'b0001, 1'b0});
        n = 0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 4'b0, 0);
            n += bus.draining;
        end
        chk("drain length", n, 4);
        drive(0, 0, 4'b0, 0);
        chk("ack pulse", {bus.irq_ack, bus.pc_en, bus.stage_clr}, {1'b1, 1'b1, 4'b0001});
        drive(0, 0, 4'b0, 0);
        chk("after ack", {bus.irq_ack, bus.draining, bus.stage_clr}, 6'b0);
        // drain with a 2-cycle stall in the middle
        drive(0, 0, 4'b0, 1);
        drive(0, 0, 4'b0, 0);
        n = bus.draining;
        drive(0, 0, 4'b0010, 0); n += bus.draining;
        drive(0, 0, 4'b0010, 0); n += bus.draining;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive(0, 0, 4'b0, 0);
            if (bus.irq_ack) got = 1;
            else n += bus.draining;
        end
        chk("stalled drain ack seen", got, 1);
        chk("stalled drain length", n, 6);
        idle(1);
        // hazards inside a drain, then a stall on the ACK cycle
        drive(0, 0, 4'b0, 1);
        drive(0, 1, 4'b0, 0);
        chk("drain branch", {bus.pc_en, bus.stage_clr}, {1'b0, 4'b0111});
        drive(1, 0, 4'b0, 0);
        chk("drain load", {bus.pc_en, bus.stage_en, bus.stage_clr}, {1'b0, 4'b1110, 4'b0011});
        idle(2);
        drive(0, 0, 4'b1000, 0);
        chk("ack held by stall", {bus.irq_ack, bus.pc_en}, 2'b00);
        drive(0, 0, 4'b0, 0);
        chk("ack after stall", bus.irq_ack, 1);
        idle(2);
        // watchdog
        first_hi = -1;
        for (int i = 0; i < 70; i++) begin
            drive(0, 0, 4'b0001, 0);
            if (first_hi < 0 && bus.stall_timeout) first_hi = i;
        end
        chk("timeout rise cycle", first_hi, 64);
        chk("timeout held", bus.stall_timeout, 1);
        drive(0, 0, 4'b0, 0);
        chk("timeout on release cycle", bus.stall_timeout, 1);
        drive(0, 0, 4'b0, 0);
        chk("timeout cleared", bus.stall_timeout, 0);
        // reset in the middle of a drain
        drive(0, 0, 4'b0, 1);
        idle(2);
        reset = 1'b1;
        #1;
        chk("mid-drain reset", {bus.pc_en, bus.stage_en, bus.stage_clr, bus.irq_ack, bus.draining},
            {1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0});
        @(posedge clk); #1 reset = 1'b0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 4'b0, 0);
            got |= bus.irq_ack | bus.draining;
        end
        chk("no ack after reset", got, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
